// File: rtl/seq_shl.sv
// seq_shl: multi-cycle logical shift-left, one bit per clock, start/busy/done handshake.
// Optional rotate-left mode is compiled in when SEQ_SHL_ROL_EN is defined.
module seq_shl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
`ifdef SEQ_SHL_ROL_EN
   input  logic             rotate,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [31:0]      B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_load_cnt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_fill;

`ifdef SEQ_SHL_ROL_EN
   logic r_rot;
   logic w_rot_nxt;

   // Rotation wraps modulo WIDTH; shifting saturates at WIDTH (all bits gone).
   always_comb begin
      if (rotate)
         w_load_cnt = CNT_W'(B % 32'(WIDTH));
      else if (B >= 32'(WIDTH))
         w_load_cnt = CNT_W'(WIDTH);
      else
         w_load_cnt = B[CNT_W-1:0];
   end

   assign w_fill = r_rot ? r_result[WIDTH-1] : 1'b0;
`else
   always_comb begin
      if (B >= 32'(WIDTH))
         w_load_cnt = CNT_W'(WIDTH);
      else
         w_load_cnt = B[CNT_W-1:0];
   end

   assign w_fill = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (clear)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values; registered below so every output is a flop
   always_comb begin
      w_result_nxt = r_result;
      w_cnt_nxt    = r_cnt;
`ifdef SEQ_SHL_ROL_EN
      w_rot_nxt    = r_rot;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_result_nxt = A;
               w_cnt_nxt    = w_load_cnt;
`ifdef SEQ_SHL_ROL_EN
               w_rot_nxt    = rotate;
`endif
            end
         end
         S_SHIFT: begin
            if (r_cnt != '0) begin
               w_result_nxt = {r_result[WIDTH-2:0], w_fill};
               w_cnt_nxt    = r_cnt - CNT_W'(1);
            end
         end
         default: ;
      endcase
      w_done_nxt = (r_state == S_SHIFT) && (r_cnt == '0);
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_cnt    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SEQ_SHL_ROL_EN
         r_rot    <= 1'b0;
`endif
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_result <= w_result_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
`ifdef SEQ_SHL_ROL_EN
         r_rot    <= w_rot_nxt;
`endif
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign Result = r_result;

endmodule

// File: tb/tb_seq_shl.sv
// Directed self-checking bench for seq_shl: latency, result, handshake, clear priority.
// Rotate cases are included when SEQ_SHL_ROL_EN is defined.
module tb_seq_shl;

   localparam int WIDTH = 32;

   logic              clock;
   logic              clear;
   logic              start;
   logic [WIDTH-1:0]  A;
   logic [31:0]       B;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  Result;
`ifdef SEQ_SHL_ROL_EN
   logic              rotate;
`endif

   int checks   = 0;
   int failures = 0;

   seq_shl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clock  (clock),
      .clear  (clear),
      .start  (start),
`ifdef SEQ_SHL_ROL_EN
      .rotate (rotate),
`endif
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Start one operation and follow it to completion, checking latency and value.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic rot, input logic [31:0] exp_res, input int exp_n);
      int busy_cnt;
      int done_at;
      int done_pulses;
      logic [31:0] held;
      @(negedge clock);
      A = a; B = b; start = 1'b1;
`ifdef SEQ_SHL_ROL_EN
      rotate = rot;
`endif
      @(posedge clock);
      #1;
      start = 1'b0;
      A = 32'h5A5A_A5A5;
      B = 32'h0000_0002;
`ifdef SEQ_SHL_ROL_EN
      rotate = ~rot;
`endif
      checks++;
      if (Result !== a) begin
         failures++;
         $display("FAIL %s_load: got %h expected %h", name, Result, a);
      end
      busy_cnt = busy ? 1 : 0;
      done_at = -1;
      done_pulses = 0;
      held = '0;
      for (int k = 1; k <= WIDTH + 8; k++) begin
         @(posedge clock);
         #1;
         if (done) begin
            done_pulses++;
            if (done_at < 0) begin
               done_at = k;
               held = Result;
            end
         end
         if (busy) busy_cnt++;
         else break;
      end
      checks++;
      if (done_at !== exp_n + 1) begin
         failures++;
         $display("FAIL %s_done_latency: got %0d expected %0d", name, done_at, exp_n + 1);
      end
      checks++;
      if (done_pulses !== 1) begin
         failures++;
         $display("FAIL %s_done_pulses: got %0d expected 1", name, done_pulses);
      end
      checks++;
      if (held !== exp_res) begin
         failures++;
         $display("FAIL %s_result: got %h expected %h", name, held, exp_res);
      end
      checks++;
      if (busy_cnt !== exp_n + 2) begin
         failures++;
         $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, exp_n + 2);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== exp_res) begin
         failures++;
         $display("FAIL %s_idle_hold: got busy=%b done=%b res=%h expected busy=0 done=0 res=%h",
                  name, busy, done, Result, exp_res);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      clear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
         failures++;
         $display("FAIL reset: got busy=%b done=%b res=%h expected busy=0 done=0 res=00000000",
                  busy, done, Result);
      end
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_shift();
      run_op("shl4",  32'h0000_0001, 32'd4,  1'b0, 32'h0000_0010, 4);
      run_op("shl0",  32'hDEAD_BEEF, 32'd0,  1'b0, 32'hDEAD_BEEF, 0);
      run_op("shl8",  32'h1234_5678, 32'd8,  1'b0, 32'h3456_7800, 8);
      run_op("shl31", 32'h0000_0001, 32'd31, 1'b0, 32'h8000_0000, 31);
   endtask

   task automatic test_saturate();
      run_op("b32",     32'hFFFF_FFFF, 32'd32,        1'b0, 32'h0, 32);
      run_op("bhigh",   32'hFFFF_FFFF, 32'h8000_0003, 1'b0, 32'h0, 32);
      run_op("bmax",    32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 32'h0, 32);
   endtask

   task automatic test_repulse();
      int done_at;
      @(negedge clock);
      A = 32'h8000_0001; B = 32'd31; start = 1'b1;
`ifdef SEQ_SHL_ROL_EN
      rotate = 1'b0;
`endif
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      A = 32'h1234_5678; B = 32'd2; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      done_at = -1;
      for (int k = 4; k <= WIDTH + 8; k++) begin
         @(posedge clock);
         #1;
         if (done) begin
            done_at = k;
            break;
         end
      end
      checks++;
      if (done_at !== 32) begin
         failures++;
         $display("FAIL repulse_latency: got %0d expected 32", done_at);
      end
      checks++;
      if (Result !== 32'h8000_0000) begin
         failures++;
         $display("FAIL repulse_result: got %h expected 80000000", Result);
      end
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL repulse_busy_end: got %b expected 0", busy);
      end
   endtask

   task automatic test_clear_mid();
      @(negedge clock);
      A = 32'h0000_FFFF; B = 32'd10; start = 1'b1;
`ifdef SEQ_SHL_ROL_EN
      rotate = 1'b0;
`endif
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      clear = 1'b1; start = 1'b1; A = 32'h5555_5555; B = 32'd2;
      @(posedge clock);
      #1;
      clear = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
         failures++;
         $display("FAIL clear_mid: got busy=%b done=%b res=%h expected busy=0 done=0 res=00000000",
                  busy, done, Result);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
         failures++;
         $display("FAIL clear_noload: got busy=%b done=%b res=%h expected busy=0 done=0 res=00000000",
                  busy, done, Result);
      end
      run_op("after_clear", 32'h0000_0001, 32'd1, 1'b0, 32'h0000_0002, 1);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_a", 32'h0000_0003, 32'd2, 1'b0, 32'h0000_000C, 2);
      run_op("b2b_b", 32'hF000_000F, 32'd4, 1'b0, 32'h0000_00F0, 4);
   endtask

`ifdef SEQ_SHL_ROL_EN
   task automatic test_rotate();
      run_op("rol33", 32'h8000_0001, 32'd33, 1'b1, 32'h0000_0003, 1);
      run_op("rol4",  32'h1234_5678, 32'd4,  1'b1, 32'h2345_6781, 4);
      run_op("rol32", 32'hCAFE_F00D, 32'd32, 1'b1, 32'hCAFE_F00D, 0);
   endtask
`endif

   initial begin
      clear = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
`ifdef SEQ_SHL_ROL_EN
      rotate = 1'b0;
`endif
      test_reset();
      test_shift();
      test_saturate();
      test_repulse();
      test_clear_mid();
      test_back_to_back();
`ifdef SEQ_SHL_ROL_EN
      test_rotate();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
